// File: rtl/gpu_mem_pkg.sv
// Shared types for the data-memory responder: FSM states, access op and stat width.
package gpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2,
    RELEASE = 2'd3
  } mem_resp_state_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } mem_op_t;

  localparam int STAT_BITS = 16;

endpackage

// File: rtl/data_mem_responder_if.sv
// Per-thread data-memory valid/ready bus: master = core LSUs, slave = responder.
interface data_mem_responder_if #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
);
  logic [NUM_CONSUMERS-1:0]                read_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] read_address;
  logic [NUM_CONSUMERS-1:0]                read_ready;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] read_data;
  logic [NUM_CONSUMERS-1:0]                write_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] write_address;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] write_data;
  logic [NUM_CONSUMERS-1:0]                write_ready;

  modport master (
    output read_valid, read_address, write_valid, write_address, write_data,
    input  read_ready, read_data, write_ready
  );

  modport slave (
    input  read_valid, read_address, write_valid, write_address, write_data,
    output read_ready, read_data, write_ready
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting index at or after ptr_i.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] gnt_idx_o,
  output logic         gnt_vld_o
);
  logic [W-1:0] idx;

  // Scan from the farthest offset down so the nearest hit to ptr_i wins.
  always_comb begin
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    idx       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = W'((int'(ptr_i) + k) % N);
      if (req_i[idx]) begin
        gnt_idx_o = idx;
        gnt_vld_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/data_mem_responder.sv
// Round-robin serialising responder onto a single-port array.
// Optional stats counters: define DATA_MEM_RESPONDER_STATS_EN.
module data_mem_responder
  import gpu_mem_pkg::*;
#(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int LATENCY       = 2
) (
  input  logic clk,
  input  logic reset,
  data_mem_responder_if.slave bus
`ifdef DATA_MEM_RESPONDER_STATS_EN
  ,
  output logic [STAT_BITS-1:0] stat_reads,
  output logic [STAT_BITS-1:0] stat_writes,
  output logic [STAT_BITS-1:0] stat_wait_cycles
`endif
);
  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam logic [NUM_CONSUMERS-1:0] ONE = {{(NUM_CONSUMERS-1){1'b0}}, 1'b1};

  mem_resp_state_t state_q, state_d;
  mem_op_t         op_q, op_d;
  logic [CW-1:0]        rr_ptr_q, rr_ptr_d, ch_q, ch_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rdata_q;
  logic [DATA_BITS-1:0] mem_q [2**ADDR_BITS];

  logic [NUM_CONSUMERS-1:0] rv, wv, ch_oh, busy, req;
  logic [CW-1:0]            gnt_idx;
  logic                     gnt_vld, access;

  assign rv     = bus.read_valid;
  assign wv     = bus.write_valid;
  assign ch_oh  = ONE << ch_q;
  assign busy   = (state_q == RESPOND || state_q == RELEASE) ? ch_oh : '0;
  assign req    = (rv | wv) & ~busy;
  assign access = (state_q == ACCESS) && (cnt_q == 4'd0);

  rr_arbiter #(.N(NUM_CONSUMERS), .W(CW)) u_arb (
    .req_i     (req),
    .ptr_i     (rr_ptr_q),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rr_ptr_d = rr_ptr_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: if (gnt_vld) begin
        ch_d    = gnt_idx;
        op_d    = wv[gnt_idx] ? WRITE : READ;
        addr_d  = wv[gnt_idx] ? bus.write_address[gnt_idx] : bus.read_address[gnt_idx];
        wdata_d = bus.write_data[gnt_idx];
        cnt_d   = 4'(LATENCY - 1);
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) state_d = RESPOND;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESPOND: if (!((op_q == WRITE) ? wv[ch_q] : rv[ch_q])) state_d = RELEASE;
      RELEASE: begin
        rr_ptr_d = (ch_q == CW'(NUM_CONSUMERS - 1)) ? '0 : ch_q + CW'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= READ;
      rr_ptr_q <= '0;
      ch_q     <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rr_ptr_q <= rr_ptr_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      if (access && op_q == READ) rdata_q[ch_q] <= mem_q[addr_q];
    end
  end

  // Array is deliberately not reset; a reset during ACCESS drops state_q before the commit edge.
  always_ff @(posedge clk) begin
    if (access && op_q == WRITE) mem_q[addr_q] <= wdata_q;
  end

  assign bus.read_data   = rdata_q;
  assign bus.read_ready  = (state_q == RESPOND && op_q == READ)  ? ch_oh : '0;
  assign bus.write_ready = (state_q == RESPOND && op_q == WRITE) ? ch_oh : '0;

`ifdef DATA_MEM_RESPONDER_STATS_EN
  logic [NUM_CONSUMERS-1:0] held_oh;
  logic                     wait_cyc;

  // A channel is waiting when it requests but holds neither the current nor the fresh grant.
  assign held_oh  = (state_q != IDLE) ? ch_oh : (gnt_vld ? (ONE << gnt_idx) : '0);
  assign wait_cyc = |(req & ~held_oh);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_reads       <= '0;
      stat_writes      <= '0;
      stat_wait_cycles <= '0;
    end else begin
      if (access && op_q == READ  && stat_reads  != '1) stat_reads  <= stat_reads  + 1'b1;
      if (access && op_q == WRITE && stat_writes != '1) stat_writes <= stat_writes + 1'b1;
      if (wait_cyc && stat_wait_cycles != '1) stat_wait_cycles <= stat_wait_cycles + 1'b1;
    end
  end
`endif
endmodule
